// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, width helpers and saturating add
// for the vector neuron MAC (neuron_mac_vec, mac_lane_tree).
package neuron_pkg;

  localparam int SAT_W       = 128;
  localparam int DATA_W_DEF  = 16;
  localparam int N_LANES_DEF = 4;

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    HOLD
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
    logic first;
  } beat_flags_t;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    sat;
  } sat_res_t;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int lsum_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  localparam int PROD_W_DEF = prod_w(DATA_W_DEF);
  localparam int LSUM_W_DEF = lsum_w(DATA_W_DEF, N_LANES_DEF);

  // Both operands must already fit in w signed bits, so the
  // wide sum cannot wrap; the result is clamped to w bits.
  function automatic sat_res_t sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] s;
    sat_res_t                r;
    one = SAT_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    s   = a + b;
    r.val = s;
    r.sat = 1'b0;
    if (s > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// mac_lane_tree: registered per-lane products (stage 1) with
// flags/bias, plus the sign-extended lane-sum adder tree.
// Ports: clk, reset, in_flags/in_bias/in_data/in_wgt (beat in),
//        s1_flags, s1_bias, s1_lsum (stage-1 view out).
module mac_lane_tree
  import neuron_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_W_DEF,
  parameter  int N_LANES    = N_LANES_DEF,
  parameter  int ACC_WIDTH  = 2 * DATA_WIDTH + 8,
  localparam int PROD_W     = prod_w(DATA_WIDTH),
  localparam int LSUM_W     = lsum_w(DATA_WIDTH, N_LANES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  beat_flags_t                     in_flags,
  input  logic signed [ACC_WIDTH-1:0]     in_bias,
  input  logic [N_LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [N_LANES*DATA_WIDTH-1:0]   in_wgt,
  output beat_flags_t                     s1_flags,
  output logic signed [ACC_WIDTH-1:0]     s1_bias,
  output logic signed [LSUM_W-1:0]        s1_lsum
);

  logic signed [PROD_W-1:0] prod [N_LANES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_flags <= '0;
      s1_bias  <= '0;
      for (int i = 0; i < N_LANES; i++)
        prod[i] <= '0;
    end else begin
      s1_flags <= in_flags;
      if (in_flags.valid) begin
        s1_bias <= in_bias;
        for (int i = 0; i < N_LANES; i++)
          prod[i] <=
            PROD_W'(signed'(in_data[i*DATA_WIDTH +: DATA_WIDTH])) *
            PROD_W'(signed'(in_wgt[i*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  always_comb begin
    s1_lsum = '0;
    for (int i = 0; i < N_LANES; i++)
      s1_lsum = s1_lsum + LSUM_W'(prod[i]);
  end

endmodule

// File: rtl/neuron_mac_vec.sv
// neuron_mac_vec: N-lane saturating MAC, one biased result per
// tlast-delimited frame. Optional macro NEURON_RELU_EN clamps
// negative results to 0.
// Ports: clk, reset; s_axis_* beat input (tdata=inputs,
// tdata_1=weights, tlast, bias); m_axis_* result (tuser=sat);
// frame_count = results accepted downstream.
module neuron_mac_vec
  import neuron_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_W_DEF,
  parameter  int N_LANES    = N_LANES_DEF,
  parameter  int ACC_WIDTH  = 2 * DATA_WIDTH + 8,
  localparam int LSUM_W     = lsum_w(DATA_WIDTH, N_LANES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [N_LANES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_LANES*DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic                          s_axis_tlast,
  input  logic signed [ACC_WIDTH-1:0]   bias,
  output logic signed [ACC_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic [31:0]                   frame_count
);

  state_t                     state;
  state_t                     state_nxt;
  logic                       in_frame;
  logic                       beat;
  logic                       out_hs;
  beat_flags_t                in_flags;
  beat_flags_t                s1_flags;
  logic signed [ACC_WIDTH-1:0] s1_bias;
  logic signed [LSUM_W-1:0]    s1_lsum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] nxt;
  logic signed [ACC_WIDTH-1:0] res;
  logic                       acc_sat;
  logic                       frame_sat;
  sat_res_t                   sr;
  logic                       unused_hi;

  assign s_axis_tready = (state == ACCUM);
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign out_hs        = m_axis_tvalid & m_axis_tready;

  assign in_flags.valid = beat;
  assign in_flags.last  = s_axis_tlast;
  assign in_flags.first = ~in_frame;

  mac_lane_tree #(
    .DATA_WIDTH(DATA_WIDTH),
    .N_LANES   (N_LANES),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_tree (
    .clk     (clk),
    .reset   (reset),
    .in_flags(in_flags),
    .in_bias (bias),
    .in_data (s_axis_tdata),
    .in_wgt  (s_axis_tdata_1),
    .s1_flags(s1_flags),
    .s1_bias (s1_bias),
    .s1_lsum (s1_lsum)
  );

  // First beat starts from the bias, so it is added once.
  always_comb begin
    base      = s1_flags.first ? s1_bias : acc;
    sr        = sat_add(SAT_W'(base), SAT_W'(s1_lsum), ACC_WIDTH);
    nxt       = sr.val[ACC_WIDTH-1:0];
    unused_hi = ^sr.val[SAT_W-1:ACC_WIDTH];
    frame_sat = sr.sat | (~s1_flags.first & acc_sat);
  end

`ifdef NEURON_RELU_EN
  assign res = nxt[ACC_WIDTH-1] ? '0 : nxt;
`else
  assign res = nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      in_frame <= 1'b0;
    else if (beat)
      in_frame <= ~s_axis_tlast;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ACCUM;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM: if (beat && s_axis_tlast) state_nxt = FLUSH;
      FLUSH: if (s1_flags.valid && s1_flags.last) state_nxt = HOLD;
      HOLD:  if (out_hs) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      acc_sat       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_count   <= '0;
    end else begin
      if (out_hs) begin
        m_axis_tvalid <= 1'b0;
        frame_count   <= frame_count + 32'd1;
      end
      if (s1_flags.valid) begin
        if (s1_flags.last) begin
          m_axis_tdata  <= res;
          m_axis_tuser  <= frame_sat;
          m_axis_tvalid <= 1'b1;
          acc           <= '0;
          acc_sat       <= 1'b0;
        end else begin
          acc     <= nxt;
          acc_sat <= frame_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_vec.sv
// tb_neuron_mac_vec: directed frame vectors plus hand-written
// latency, backpressure and mid-frame reset sequences.
module tb_neuron_mac_vec;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               s_tvalid;
  logic               s_tready;
  logic [31:0]        s_tdata;
  logic [31:0]        s_tdata_1;
  logic               s_tlast;
  logic signed [17:0] bias;
  logic signed [17:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tuser;
  logic [31:0]        frame_count;

  int total = 0;
  int bad   = 0;
  int fcnt  = 0;

  typedef struct {
    string       name;
    int          nb;
    bit          gap;
    logic [31:0] xd;
    logic [31:0] wd;
    int          b;
    int          e;
    bit          u;
  } vec_t;

  vec_t vt[8];

  neuron_mac_vec #(
    .DATA_WIDTH(8),
    .N_LANES   (4),
    .ACC_WIDTH (18)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tdata_1(s_tdata_1),
    .s_axis_tlast  (s_tlast),
    .bias          (bias),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] p4(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic int relu_of(int e);
    return (RELU && e < 0) ? 0 : e;
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic handshake(input string nm);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    fcnt++;
    chk({nm, "_vld_drop"}, longint'(m_tvalid), 0);
    chk({nm, "_rdy_back"}, longint'(s_tready), 1);
    chk({nm, "_fcount"}, longint'(frame_count), longint'(fcnt));
  endtask

  task automatic run_frame(input vec_t v);
    for (int b = 0; b < v.nb; b++) begin
      @(negedge clk);
      if (b > 0 && v.gap) begin
        s_tvalid = 1'b0;
        @(negedge clk);
      end
      s_tvalid  = 1'b1;
      s_tdata   = v.xd;
      s_tdata_1 = v.wd;
      s_tlast   = (b == v.nb - 1);
      bias      = 18'(v.b);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk({v.name, "_lat1"}, longint'(m_tvalid), 0);
    chk({v.name, "_flush_rdy"}, longint'(s_tready), 0);
    @(negedge clk);
    chk({v.name, "_lat2"}, longint'(m_tvalid), 1);
    chk({v.name, "_data"}, longint'(m_tdata), longint'(relu_of(v.e)));
    chk({v.name, "_user"}, longint'(m_tuser), longint'(v.u));
    handshake(v.name);
  endtask

  initial begin
    vt[0] = '{"single", 1, 0, p4(3, 3, 3, 3), p4(2, 2, 2, 2),
              10, 34, 0};
    vt[1] = '{"three_gap", 3, 1, p4(1, 2, 3, 4), p4(1, 1, 1, 1),
              0, 30, 0};
    vt[2] = '{"sat_pos", 5, 0, p4(127, 127, 127, 127),
              p4(127, 127, 127, 127), 0, 131071, 1};
    vt[3] = '{"after_sat", 2, 0, p4(1, 1, 1, 1), p4(2, 2, 2, 2),
              -3, 13, 0};
    vt[4] = '{"neg", 1, 0, p4(5, 5, 5, 5), p4(-1, -1, -1, -1),
              0, -20, 0};
    vt[5] = '{"sat_neg", 4, 0, p4(-128, -128, -128, -128),
              p4(127, 127, 127, 127), 0, -131072, 1};
    vt[6] = '{"bias_clamp", 1, 0, p4(1, 1, 1, 1), p4(1, 1, 1, 1),
              131071, 131071, 1};
    vt[7] = '{"neg_bias", 2, 0, p4(-1, 2, -3, 4), p4(5, 5, 5, 5),
              -50, -30, 0};

    reset     = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tdata_1 = '0;
    s_tlast   = 1'b0;
    bias      = '0;
    m_tready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tready", longint'(s_tready), 1);
    chk("rst_tvalid", longint'(m_tvalid), 0);
    chk("rst_tdata", longint'(m_tdata), 0);
    chk("rst_tuser", longint'(m_tuser), 0);
    chk("rst_fcount", longint'(frame_count), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_frame(vt[i]);

    // Backpressure: result held 10 cycles while the next beat
    // waits at the input with tvalid high.
    @(negedge clk);
    s_tvalid  = 1'b1;
    s_tdata   = p4(1, 1, 1, 1);
    s_tdata_1 = p4(7, 7, 7, 7);
    s_tlast   = 1'b1;
    bias      = 18'sd2;
    @(negedge clk);
    s_tdata   = p4(2, 2, 2, 2);
    s_tdata_1 = p4(2, 2, 2, 2);
    bias      = 18'sd1;
    @(negedge clk);
    chk("hold_first_vld", longint'(m_tvalid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_data", longint'(m_tdata), 30);
      chk("hold_vld", longint'(m_tvalid), 1);
      chk("hold_rdy", longint'(s_tready), 0);
    end
    handshake("hold");
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("queued_lat1", longint'(m_tvalid), 0);
    @(negedge clk);
    chk("queued_lat2", longint'(m_tvalid), 1);
    chk("queued_data", longint'(m_tdata), 17);
    chk("queued_user", longint'(m_tuser), 0);
    handshake("queued");

    // Reset after two beats of a frame: nothing may leak.
    @(negedge clk);
    s_tvalid  = 1'b1;
    s_tdata   = p4(9, 9, 9, 9);
    s_tdata_1 = p4(9, 9, 9, 9);
    s_tlast   = 1'b0;
    bias      = 18'sd100;
    @(negedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fcnt  = 0;
    chk("midrst_fcount", longint'(frame_count), 0);
    chk("midrst_rdy", longint'(s_tready), 1);
    run_frame('{"post_rst", 1, 0, p4(1, 1, 1, 1),
                p4(1, 1, 1, 1), 0, 4, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
